keycode_event_queue: RTL and testbench

- Sequences the raw 8-bit keycode input into a buffered stream of discrete key events: press, auto-repeat and release.
- The CPU drains the stream through an Avalon-MM slave. The software no longer polls the level-valued keycode PIO every frame, and no keystrokes are lost between polls.
- Implements DAS/ARR auto-repeat for game piece movement and raises an interrupt while events are pending.
- Sits between the USB-keyboard keycode source and the Nios II data bus.

---
 rtl/keycode_pkg.sv | 31 +++
 rtl/keycode_event_fifo.sv | 78 +++++++
 rtl/keycode_event_queue.sv | 170 +++++++++++++++++
 tb/tb_keycode_event_queue.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keycode_pkg.sv
// Shared definitions for the keycode event queue.
//   - event type codes carried in bits [9:8] of every queued event word
//   - Avalon word addresses of the four slave registers
//   - CONTROL register bit positions and reset value
//   - key tracker state encoding
package keycode_pkg;

  localparam int EV_W = 10;  // {type[1:0], keycode[7:0]}

  localparam logic [1:0] EV_PRESS   = 2'b01;
  localparam logic [1:0] EV_REPEAT  = 2'b10;
  localparam logic [1:0] EV_RELEASE = 2'b11;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_CONTROL = 2'd2;
  localparam logic [1:0] ADDR_CLEAR   = 2'd3;

  localparam int CTRL_ENABLE    = 0;
  localparam int CTRL_IRQ_EN    = 1;
  localparam int CTRL_REPEAT_EN = 2;

  localparam logic [2:0] CTRL_RESET = 3'b101;  // enable=1, irq_en=0, repeat_en=1

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // no key held
    ST_DAS  = 2'd1,  // key held, waiting for the first repeat
    ST_ARR  = 2'd2   // key held, repeating at the auto-repeat rate
  } trk_state_e;

endpackage

// File: rtl/keycode_event_fifo.sv
// Synchronous event FIFO.
//   clk, reset_n : clock, asynchronous active-low reset (pointers/count only)
//   flush        : empties the FIFO; wins over a push or pop on the same edge
//   push/push_data : write request; dropped when full
//   pop          : read request; ignored when empty
//   head         : oldest entry (valid when !empty)
//   count/full/empty : occupancy as of the last edge
// DEPTH must be a power of two so the pointers wrap naturally.
module keycode_event_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = keycode_pkg::EV_W
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    empty    = (count_q == '0);
    full     = (count_q == CNT_W'(DEPTH));
    do_push  = push && !full && !flush;
    do_pop   = pop && !empty && !flush;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers and count
  // define which entries are valid, and a reset-free array maps onto RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/keycode_event_queue.sv
// Keycode event queue: turns the level-valued 8-bit keycode into a buffered
// stream of PRESS / REPEAT / RELEASE events drained over an Avalon-MM slave.
//   clk, reset_n  : system clock, asynchronous active-low reset
//   in_port[7:0]  : raw keycode (0 = no key), asynchronous to clk
//   address[1:0], chipselect, read, write, writedata[31:0] : Avalon-MM slave
//   readdata[31:0]: registered read data (latency 1, holds between reads)
//   irq           : registered level interrupt, irq_en & events pending
// Registers: 0 DATA (pop head), 1 STATUS, 2 CONTROL, 3 CLEAR (write flushes).
module keycode_event_queue
  import keycode_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int DAS_DELAY  = 10000000,
  parameter int ARR_PERIOD = 2500000,
  parameter int CNT_W      = 24
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  in_port,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq
);

  localparam logic [CNT_W-1:0] DAS_RELOAD = CNT_W'(DAS_DELAY - 1);
  localparam logic [CNT_W-1:0] ARR_RELOAD = CNT_W'(ARR_PERIOD - 1);

  logic [7:0]       sync1_q, sync2_q;
  trk_state_e       state_q, state_d;
  logic [7:0]       last_code_q, last_code_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       ctrl_q, ctrl_d;
  logic             overflow_q, overflow_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             irq_q, irq_d;

  logic             trk_push;
  logic [EV_W-1:0]  trk_word;
  logic             fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic [EV_W-1:0]  fifo_head;
  logic [$clog2(DEPTH):0] fifo_count;
  logic             rd_en, wr_en;
  logic             unused_writedata;

  assign unused_writedata = ^writedata[31:3];

  // Key tracker. Only the second synchronizer stage is ever looked at.
  always_comb begin
    state_d     = state_q;
    last_code_d = last_code_q;
    cnt_d       = cnt_q;
    trk_push    = 1'b0;
    trk_word    = {EV_PRESS, sync2_q};
    if (!ctrl_q[CTRL_ENABLE]) begin
      state_d     = ST_IDLE;
      last_code_d = '0;
      cnt_d       = '0;
    end else if (state_q == ST_IDLE) begin
      if (sync2_q != 8'd0) begin
        trk_push    = 1'b1;
        last_code_d = sync2_q;
        cnt_d       = DAS_RELOAD;
        state_d     = ST_DAS;
      end
    end else if (sync2_q == 8'd0) begin
      trk_push    = 1'b1;
      trk_word    = {EV_RELEASE, last_code_q};
      last_code_d = '0;
      state_d     = ST_IDLE;
    end else if (sync2_q != last_code_q) begin
      // Rollover to a new key: press the new one, no release for the old one.
      trk_push    = 1'b1;
      last_code_d = sync2_q;
      cnt_d       = DAS_RELOAD;
      state_d     = ST_DAS;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else if (state_q == ST_ARR || ctrl_q[CTRL_REPEAT_EN]) begin
      // With repeat_en low the DAS count parks at zero until the key changes.
      trk_push = 1'b1;
      trk_word = {EV_REPEAT, last_code_q};
      cnt_d    = ARR_RELOAD;
      state_d  = ST_ARR;
    end
  end

  // Register decode, overflow flag and interrupt.
  always_comb begin
    rd_en      = chipselect && read;
    wr_en      = chipselect && write;
    fifo_pop   = 1'b0;
    fifo_flush = wr_en && (address == ADDR_CLEAR);
    readdata_d = readdata_q;
    ctrl_d     = ctrl_q;
    overflow_d = overflow_q;
    irq_d      = ctrl_q[CTRL_IRQ_EN] && !fifo_empty;

    if (rd_en) begin
      readdata_d = '0;
      case (address)
        ADDR_DATA: begin
          if (!fifo_empty) begin
            readdata_d = {1'b1, 21'd0, fifo_head};
            fifo_pop   = 1'b1;
          end
        end
        ADDR_STATUS: begin
          readdata_d[4:0] = 5'(fifo_count);
          readdata_d[8]   = overflow_q;
          readdata_d[9]   = fifo_empty;
        end
        ADDR_CONTROL: readdata_d[2:0] = ctrl_q;
        default:      readdata_d = '0;
      endcase
    end

    if (wr_en && address == ADDR_CONTROL) ctrl_d = writedata[2:0];

    if (fifo_flush)                 overflow_d = 1'b0;
    else if (trk_push && fifo_full) overflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      state_q     <= ST_IDLE;
      last_code_q <= '0;
      cnt_q       <= '0;
      ctrl_q      <= CTRL_RESET;
      overflow_q  <= 1'b0;
      readdata_q  <= '0;
      irq_q       <= 1'b0;
    end else begin
      sync1_q     <= in_port;
      sync2_q     <= sync1_q;
      state_q     <= state_d;
      last_code_q <= last_code_d;
      cnt_q       <= cnt_d;
      ctrl_q      <= ctrl_d;
      overflow_q  <= overflow_d;
      readdata_q  <= readdata_d;
      irq_q       <= irq_d;
    end
  end

  keycode_event_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EV_W)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (fifo_flush),
    .push      (trk_push),
    .push_data (trk_word),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_keycode_event_queue.sv
// Self-checking bench for keycode_event_queue (DEPTH=4, DAS=4, ARR=2).
// Directed scenarios check fixed expected words; a randomized phase checks
// readdata and irq every cycle against an event-level reference model that
// works from key hold times and a queue of event words.
module tb_keycode_event_queue;
  import keycode_pkg::*;

  localparam int DEPTH = 4;
  localparam int DAS   = 4;
  localparam int ARR   = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  in_port = 8'h00;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic        irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  keycode_event_queue #(
    .DEPTH      (DEPTH),
    .DAS_DELAY  (DAS),
    .ARR_PERIOD (ARR),
    .CNT_W      (24)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_port    (in_port),
    .address    (address),
    .chipselect (chipselect),
    .read       (read),
    .write      (write),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq)
  );

  // ---------------- reference model ----------------
  int unsigned m_cyc;
  int unsigned m_press_cyc;
  logic [7:0]  m_s1, m_s2, m_last;
  bit          m_active;
  logic [2:0]  m_ctrl;
  logic [9:0]  m_q[$];
  bit          m_ovf;
  logic [31:0] m_rdata;
  logic        m_irq;

  task automatic model_reset();
    m_cyc = 0; m_press_cyc = 0;
    m_s1 = '0; m_s2 = '0; m_last = '0; m_active = 0;
    m_ctrl = 3'b101; m_q.delete(); m_ovf = 0;
    m_rdata = '0; m_irq = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    bit          ev, do_pop, was_empty, was_full;
    logic [9:0]  ev_word;
    int unsigned age;
    ev = 0; do_pop = 0; ev_word = '0;
    was_empty = (m_q.size() == 0);
    was_full  = (m_q.size() == DEPTH);

    if (!m_ctrl[0]) begin
      m_active = 0; m_last = '0;
    end else if (!m_active) begin
      if (m_s2 != 0) begin
        ev = 1; ev_word = {2'b01, m_s2};
        m_active = 1; m_last = m_s2; m_press_cyc = m_cyc;
      end
    end else if (m_s2 == 0) begin
      ev = 1; ev_word = {2'b11, m_last};
      m_active = 0; m_last = '0;
    end else if (m_s2 != m_last) begin
      ev = 1; ev_word = {2'b01, m_s2};
      m_last = m_s2; m_press_cyc = m_cyc;
    end else begin
      age = m_cyc - m_press_cyc;
      if (m_ctrl[2] && age >= DAS && ((age - DAS) % ARR) == 0) begin
        ev = 1; ev_word = {2'b10, m_last};
      end
    end

    if (chipselect && read) begin
      case (address)
        2'd0: begin
          if (was_empty) m_rdata = 32'd0;
          else begin m_rdata = 32'h8000_0000 | 32'(m_q[0]); do_pop = 1; end
        end
        2'd1: m_rdata = {22'd0, was_empty, m_ovf, 3'd0, 5'(m_q.size())};
        2'd2: m_rdata = {29'd0, m_ctrl};
        default: m_rdata = 32'd0;
      endcase
    end
    m_irq = m_ctrl[1] && !was_empty;
    if (chipselect && write && address == 2'd2) m_ctrl = writedata[2:0];

    if (chipselect && write && address == 2'd3) begin
      m_q.delete(); m_ovf = 0;
    end else begin
      if (do_pop) void'(m_q.pop_front());
      if (ev) begin
        if (was_full) m_ovf = 1;
        else m_q.push_back(ev_word);
      end
    end

    m_s2 = m_s1; m_s1 = in_port; m_cyc++;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic step();
    if (reset_n) model_edge();
    @(posedge clk); #1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] got);
    chipselect = 1; read = 1; address = a;
    step();
    chipselect = 0; read = 0;
    got = readdata;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1; write = 1; address = a; writedata = d;
    step();
    chipselect = 0; write = 0; writedata = '0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [31:0] got;
    logic [31:0] exp_rd [4] = '{32'h0000_0200, 32'h0000_0005, 32'h0, 32'h0};
    logic [1:0]  addr_rd [4] = '{ADDR_STATUS, ADDR_CONTROL, ADDR_CLEAR, ADDR_DATA};
    reset_n = 0; model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (readdata !== 32'd0) begin errors++; $display("FAIL reset_readdata: got %h want %h", readdata, 32'd0); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", irq); end
    reset_n = 1;
    foreach (exp_rd[i]) begin
      bus_read(addr_rd[i], got);
      checks++; if (got !== exp_rd[i]) begin errors++; $display("FAIL reset_reg%0d: got %h want %h", i, got, exp_rd[i]); end
    end
  endtask

  task automatic test_press_release();
    logic [31:0] got;
    logic [31:0] exp_seq [3] = '{32'h8000_011A, 32'h8000_031A, 32'h0};
    in_port = 8'h1A;
    step(); step();                       // E0, E1
    bus_read(ADDR_STATUS, got);           // E2: push lands on this edge
    checks++; if (got !== 32'h0000_0200) begin errors++; $display("FAIL pr_before_e2: got %h want %h", got, 32'h200); end
    in_port = 8'h00;
    bus_read(ADDR_STATUS, got);           // E3
    checks++; if (got !== 32'h0000_0001) begin errors++; $display("FAIL pr_count_e2: got %h want %h", got, 32'h1); end
    bus_read(ADDR_DATA, got);             // E4
    checks++; if (got !== 32'h8000_011A) begin errors++; $display("FAIL pr_press: got %h want %h", got, 32'h8000011A); end
    step();                               // E5: release pushed
    foreach (exp_seq[i]) begin
      if (i == 0) continue;
      bus_read(ADDR_DATA, got);
      checks++; if (got !== exp_seq[i]) begin errors++; $display("FAIL pr_drain%0d: got %h want %h", i, got, exp_seq[i]); end
    end
  endtask

  task automatic test_auto_repeat();
    logic [31:0] got;
    logic [31:0] exp_seq [5] = '{32'h8000_0104, 32'h8000_0204, 32'h8000_0204, 32'h8000_0204, 32'h0};
    in_port = 8'h04;
    repeat (11) step();                   // E0..E10: press E2, repeats E6/E8/E10
    in_port = 8'h00;
    repeat (3) step();                    // E12 repeat and E13 release both dropped
    bus_read(ADDR_STATUS, got);
    checks++; if (got !== 32'h0000_0104) begin errors++; $display("FAIL ar_status: got %h want %h", got, 32'h104); end
    foreach (exp_seq[i]) begin
      bus_read(ADDR_DATA, got);
      checks++; if (got !== exp_seq[i]) begin errors++; $display("FAIL ar_drain%0d: got %h want %h", i, got, exp_seq[i]); end
    end
    bus_read(ADDR_STATUS, got);
    checks++; if (got !== 32'h0000_0300) begin errors++; $display("FAIL ar_sticky_ovf: got %h want %h", got, 32'h300); end
    bus_write(ADDR_CLEAR, 32'd0);
    bus_read(ADDR_STATUS, got);
    checks++; if (got !== 32'h0000_0200) begin errors++; $display("FAIL ar_clear: got %h want %h", got, 32'h200); end
  endtask

  task automatic test_repeat_off();
    logic [31:0] got;
    logic [31:0] exp_seq [3] = '{32'h8000_0107, 32'h8000_0307, 32'h0};
    bus_write(ADDR_CONTROL, 32'h1);
    bus_read(ADDR_CONTROL, got);
    checks++; if (got !== 32'h0000_0001) begin errors++; $display("FAIL ro_control: got %h want %h", got, 32'h1); end
    in_port = 8'h07;
    repeat (20) step();
    in_port = 8'h00;
    repeat (4) step();
    bus_read(ADDR_STATUS, got);
    checks++; if (got !== 32'h0000_0002) begin errors++; $display("FAIL ro_count: got %h want %h", got, 32'h2); end
    foreach (exp_seq[i]) begin
      bus_read(ADDR_DATA, got);
      checks++; if (got !== exp_seq[i]) begin errors++; $display("FAIL ro_drain%0d: got %h want %h", i, got, exp_seq[i]); end
    end
    bus_write(ADDR_CONTROL, 32'h5);
  endtask

  task automatic test_push_pop();
    logic [31:0] got;
    logic [31:0] exp_seq [2] = '{32'h8000_0311, 32'h8000_0122};
    in_port = 8'h11;
    repeat (3) step();                    // press at E2
    in_port = 8'h00;
    repeat (3) step();                    // release at E5 -> count 2
    in_port = 8'h22;
    step(); step();
    bus_read(ADDR_DATA, got);             // pop coincides with PRESS 0x22 push
    checks++; if (got !== 32'h8000_0111) begin errors++; $display("FAIL pp_oldest: got %h want %h", got, 32'h80000111); end
    bus_read(ADDR_STATUS, got);
    checks++; if (got !== 32'h0000_0002) begin errors++; $display("FAIL pp_count: got %h want %h", got, 32'h2); end
    foreach (exp_seq[i]) begin
      bus_read(ADDR_DATA, got);
      checks++; if (got !== exp_seq[i]) begin errors++; $display("FAIL pp_order%0d: got %h want %h", i, got, exp_seq[i]); end
    end
    in_port = 8'h00;
    repeat (4) step();
    bus_write(ADDR_CLEAR, 32'd0);
    // Pop of an empty FIFO on the same edge as a push.
    in_port = 8'h3C;
    step(); step();
    bus_read(ADDR_DATA, got);
    checks++; if (got !== 32'h0) begin errors++; $display("FAIL pp_empty_pop: got %h want %h", got, 32'h0); end
    bus_read(ADDR_STATUS, got);
    checks++; if (got !== 32'h0000_0001) begin errors++; $display("FAIL pp_empty_push_kept: got %h want %h", got, 32'h1); end
    in_port = 8'h00;
    repeat (4) step();
    bus_write(ADDR_CLEAR, 32'd0);
  endtask

  task automatic test_key_change();
    logic [31:0] got;
    logic [31:0] exp_seq [4] = '{32'h8000_011A, 32'h8000_0116, 32'h8000_0316, 32'h0};
    in_port = 8'h1A;
    repeat (3) step();                    // press 0x1A at E2
    in_port = 8'h16;
    repeat (4) step();                    // press 0x16 at E5; old timer would fire at E6
    in_port = 8'h00;
    bus_read(ADDR_STATUS, got);
    checks++; if (got !== 32'h0000_0002) begin errors++; $display("FAIL kc_das_restart: got %h want %h", got, 32'h2); end
    repeat (3) step();
    foreach (exp_seq[i]) begin
      bus_read(ADDR_DATA, got);
      checks++; if (got !== exp_seq[i]) begin errors++; $display("FAIL kc_seq%0d: got %h want %h", i, got, exp_seq[i]); end
    end
  endtask

  task automatic test_clear_irq_reset();
    logic [31:0] got;
    bus_write(ADDR_CONTROL, 32'h7);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_idle: got %b want 0", irq); end
    in_port = 8'h2B;
    repeat (4) step();                    // press at E2, irq visible after E3
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_pending: got %b want 1", irq); end
    in_port = 8'h00;
    step(); step();
    bus_write(ADDR_CLEAR, 32'd0);         // coincides with the RELEASE push
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_lag: got %b want 1", irq); end
    step();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_drop: got %b want 0", irq); end
    bus_read(ADDR_STATUS, got);
    checks++; if (got !== 32'h0000_0200) begin errors++; $display("FAIL clear_wins: got %h want %h", got, 32'h200); end

    in_port = 8'h33;
    repeat (3) step();
    bus_read(ADDR_STATUS, got);
    step();                               // mid-DAS, readdata and irq nonzero
    reset_n = 0; model_reset();
    #1;
    checks++; if (readdata !== 32'd0 || irq !== 1'b0) begin
      errors++; $display("FAIL midreset_outputs: got rd=%h irq=%b want 0/0", readdata, irq);
    end
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1;
    step(); step();
    bus_read(ADDR_STATUS, got);
    checks++; if (got !== 32'h0000_0200) begin errors++; $display("FAIL midreset_no_early: got %h want %h", got, 32'h200); end
    bus_read(ADDR_STATUS, got);
    checks++; if (got !== 32'h0000_0001) begin errors++; $display("FAIL midreset_press_e2: got %h want %h", got, 32'h1); end
    bus_read(ADDR_DATA, got);
    checks++; if (got !== 32'h8000_0133) begin errors++; $display("FAIL midreset_press_word: got %h want %h", got, 32'h80000133); end
    in_port = 8'h00;
    repeat (4) step();
    bus_write(ADDR_CLEAR, 32'd0);
  endtask

  task automatic test_random();
    logic [7:0] keys [4] = '{8'h00, 8'h1A, 8'h04, 8'h29};
    int unsigned r;
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(7) == 0) in_port = keys[$urandom_range(3)];
      chipselect = 0; read = 0; write = 0; writedata = '0;
      r = $urandom_range(15);
      if (r < 4) begin
        chipselect = 1; read = 1;
        address = ($urandom_range(1) == 0) ? ADDR_DATA : ADDR_STATUS;
      end else if (r == 4 && $urandom_range(5) == 0) begin
        chipselect = 1; write = 1; address = ADDR_CLEAR;
      end else if (r == 5 && $urandom_range(5) == 0) begin
        chipselect = 1; write = 1; address = ADDR_CONTROL;
        writedata = {29'd0, 1'b1, 1'($urandom_range(1)), 1'($urandom_range(3) != 0)};
      end
      step();
      checks++; if (readdata !== m_rdata) begin errors++; $display("FAIL rand_readdata cyc%0d: got %h want %h", n, readdata, m_rdata); end
      checks++; if (irq !== m_irq) begin errors++; $display("FAIL rand_irq cyc%0d: got %b want %b", n, irq, m_irq); end
    end
    chipselect = 0; read = 0; write = 0; writedata = '0;
  endtask

  initial begin
    test_reset();
    test_press_release();
    test_auto_repeat();
    test_repeat_off();
    test_push_pop();
    test_key_change();
    test_clear_irq_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
